// File: rtl/inject_port_arbiter.sv
// Injection-port arbiter: packet-level round-robin among local requesters,
// wormhole lock from head to tail, per-VC credit flow control toward the router.
module inject_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_VCS    = 2,
  parameter int BUF_SIZE   = 8,
  parameter int DATA_WIDTH = 64,
  localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW  = 3 + VCW + DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_head,
  input  logic [NUM_REQ-1:0]            req_tail,
  input  logic [NUM_REQ*VCW-1:0]        req_vc,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [CW-1:0]                 channel_out,
  input  logic [VCW:0]                  flow_ctrl_in,
  output logic                          busy,
  output logic                          error
);

  localparam int          CRW = $clog2(BUF_SIZE + 1);
  localparam int          PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR  = NUM_REQ;
  localparam int unsigned NV  = NUM_VCS;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [VCW-1:0]   lock_vc_q, lock_vc_d;
  logic [CRW-1:0]   credit_q [NUM_VCS];
  logic [CRW-1:0]   credit_d [NUM_VCS];
  logic [CW-1:0]    channel_q, channel_d;
  logic             error_q, error_d;

  logic [VCW-1:0]   head_vc [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic             accept;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    scan;
  logic [VCW-1:0]   send_vc;
  logic [VCW-1:0]   ret_vc;

  assign ret_vc = flow_ctrl_in[VCW:1];

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      head_vc[i]  = req_vc[i*VCW +: VCW];
      eligible[i] = req_valid[i] && req_head[i] && (32'(head_vc[i]) < NV) &&
                    (credit_q[head_vc[i]] != '0);
    end
  end

  // Grant search starts at rr_ptr and wraps; in LOCKED only the owner can go.
  always_comb begin
    accept  = 1'b0;
    sel     = owner_q;
    send_vc = lock_vc_q;
    scan    = '0;
    if (state_q == IDLE) begin
      for (int unsigned k = 0; k < NR; k++) begin
        scan = PW'((32'(rr_ptr_q) + k) % NR);
        if (!accept && eligible[scan]) begin
          accept  = 1'b1;
          sel     = scan;
          send_vc = head_vc[scan];
        end
      end
    end else begin
      accept = req_valid[owner_q] && (credit_q[lock_vc_q] != '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_vc_d  = lock_vc_q;
    error_d    = error_q;
    req_ready  = '0;
    channel_d  = channel_q;
    channel_d[0] = 1'b0;

    if (accept) begin
      req_ready[sel]                       = 1'b1;
      channel_d[0]                         = 1'b1;
      channel_d[1]                         = (state_q == IDLE);
      channel_d[2]                         = req_tail[sel];
      channel_d[3 +: VCW]                  = send_vc;
      channel_d[3+VCW +: DATA_WIDTH]       = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
    end

    case (state_q)
      IDLE: begin
        if (|(req_valid & ~req_head)) error_d = 1'b1;
        if (accept) begin
          if (req_tail[sel]) begin
            rr_ptr_d = PW'((32'(sel) + 1) % NR);
          end else begin
            state_d   = LOCKED;
            owner_d   = sel;
            lock_vc_d = send_vc;
          end
        end
      end
      LOCKED: begin
        if (req_valid[owner_q] && req_head[owner_q]) error_d = 1'b1;
        if (accept && req_tail[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = PW'((32'(owner_q) + 1) % NR);
        end
      end
      default: state_d = IDLE;
    endcase

    // A send and a return on the same VC cancel; a return into a full counter saturates.
    for (int unsigned v = 0; v < NV; v++) begin
      credit_d[v] = credit_q[v];
      if (accept && (32'(send_vc) == v) && !(flow_ctrl_in[0] && (32'(ret_vc) == v))) begin
        credit_d[v] = credit_q[v] - CRW'(1);
      end else if (flow_ctrl_in[0] && (32'(ret_vc) == v) && !(accept && (32'(send_vc) == v))) begin
        if (credit_q[v] == CRW'(BUF_SIZE)) error_d = 1'b1;
        else credit_d[v] = credit_q[v] + CRW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      lock_vc_q <= '0;
      error_q   <= 1'b0;
      channel_q <= '0;
      for (int unsigned v = 0; v < NV; v++) credit_q[v] <= CRW'(BUF_SIZE);
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      lock_vc_q <= lock_vc_d;
      error_q   <= error_d;
      channel_q <= channel_d;
      for (int unsigned v = 0; v < NV; v++) credit_q[v] <= credit_d[v];
    end
  end

  assign channel_out = channel_q;
  assign busy        = (state_q == LOCKED);
  assign error       = error_q;

endmodule

// File: tb/tb_inject_port_arbiter.sv
// Bench for inject_port_arbiter: directed scenarios then random traffic,
// all checked against a packet-level reference model.
module tb_inject_port_arbiter;
  localparam int NR  = 4;
  localparam int BUF = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    req_valid = '0, req_head = '0, req_tail = '0, req_vc = '0;
  logic [255:0]  req_data = '0;
  logic [3:0]    req_ready;
  logic [67:0]   channel_out;
  logic [1:0]    flow_ctrl_in = '0;
  logic          busy, error;

  inject_port_arbiter #(.NUM_REQ(4), .NUM_VCS(2), .BUF_SIZE(8), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_head(req_head),
    .req_tail(req_tail), .req_vc(req_vc), .req_data(req_data), .req_ready(req_ready),
    .channel_out(channel_out), .flow_ctrl_in(flow_ctrl_in), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit do_check = 1'b0;
  bit gaps = 1'b0;
  int glog[$];

  // reference model state
  int          m_owner, m_rr, m_lock_vc;
  int          m_credit[2];
  bit          m_error, m_valid, m_head, m_tail;
  int          m_vc;
  logic [63:0] m_data;

  // traffic generators, one per requester
  bit          g_active[NR];
  int          g_len[NR], g_pos[NR], g_vc[NR];
  logic [63:0] g_data[NR];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_lock_vc = 0;
    m_credit[0] = BUF; m_credit[1] = BUF;
    m_error = 0; m_valid = 0; m_head = 0; m_tail = 0; m_vc = 0; m_data = '0;
  endtask

  task automatic start(input int i, input int len, input int vc);
    g_active[i] = 1; g_len[i] = len; g_pos[i] = 0; g_vc[i] = vc;
    g_data[i] = {$urandom, $urandom};
  endtask

  function automatic bit any_active();
    for (int i = 0; i < NR; i++) if (g_active[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = g_active[i] && (!gaps || $urandom_range(0, 3) != 0);
      req_head[i]  = g_active[i] && g_pos[i] == 0;
      req_tail[i]  = g_active[i] && g_pos[i] == g_len[i] - 1;
      // body flits carry the wrong VC on purpose: only the head's VC counts
      req_vc[i]    = (g_pos[i] == 0) ? 1'(g_vc[i]) : ~1'(g_vc[i]);
      req_data[i*64 +: 64] = g_data[i];
    end
    flow_ctrl_in = '0;
  endtask

  // One clock: compare at negedge, advance the model, then re-drive after posedge.
  task automatic step();
    int g, sv, rv;
    @(negedge clk);
    g = -1; sv = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_rr + k) % NR;
        if (g < 0 && req_valid[i] && req_head[i] && m_credit[req_vc[i]] > 0) g = i;
      end
    end else if (req_valid[m_owner] && m_credit[m_lock_vc] > 0) g = m_owner;

    if (do_check) begin
      chk("ready", req_ready, (g >= 0) ? (4'b1 << g) : 4'b0);
      chk("busy", busy, m_owner >= 0);
      chk("error", error, m_error);
      chk("ch_valid", channel_out[0], m_valid);
      chk("ch_data", channel_out[67:4], m_data);
      if (m_valid) chk("ch_flit", channel_out, {m_data, 1'(m_vc), m_tail, m_head, 1'b1});
      chk("credit0", dut.credit_q[0], m_credit[0]);
      chk("credit1", dut.credit_q[1], m_credit[1]);
    end
    for (int i = 0; i < NR; i++) if (req_ready[i]) glog.push_back(i);

    if (m_owner < 0) begin
      for (int i = 0; i < NR; i++) if (req_valid[i] && !req_head[i]) m_error = 1;
    end else if (req_valid[m_owner] && req_head[m_owner]) m_error = 1;

    if (g >= 0) begin
      sv = (m_owner < 0) ? int'(req_vc[g]) : m_lock_vc;
      m_valid = 1; m_head = (m_owner < 0); m_tail = req_tail[g]; m_vc = sv;
      m_data = req_data[g*64 +: 64];
      m_credit[sv]--;
      if (m_owner < 0) begin
        if (!req_tail[g]) begin m_owner = g; m_lock_vc = sv; end
        else m_rr = (g + 1) % NR;
      end else if (req_tail[g]) begin
        m_owner = -1; m_rr = (g + 1) % NR;
      end
      g_pos[g]++; g_data[g] = {$urandom, $urandom};
      if (g_pos[g] == g_len[g]) g_active[g] = 0;
    end else m_valid = 0;

    if (flow_ctrl_in[0]) begin
      rv = int'(flow_ctrl_in[1]);
      if (m_credit[rv] >= BUF) m_error = 1;
      else m_credit[rv]++;
    end
    if (reset) model_reset();
    @(posedge clk); #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic refill();
    for (int v = 0; v < 2; v++) begin
      int budget = 20;
      while (m_credit[v] < BUF && budget > 0) begin
        flow_ctrl_in = {1'(v), 1'b1};
        step();
        budget--;
      end
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NR; i++) g_active[i] = 0;
    drive();
    reset = 1;
    step(); step();
    reset = 0;
    do_check = 1;

    // reset state
    step();
    chk("rst_channel", channel_out, '0);
    chk("rst_ready", req_ready, '0);

    // 3-flit packet from req1 on VC1
    start(1, 3, 1); drive();
    run(4);
    chk("pkt_credit1", dut.credit_q[1], 4'd5);

    // four single-flit packets, rr pointer now at 2
    for (int i = 0; i < NR; i++) start(i, 1, 0);
    drive(); glog.delete();
    run(5);
    chk("rr_count", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("rr_g0", glog[0], 2); chk("rr_g1", glog[1], 3);
      chk("rr_g2", glog[2], 0); chk("rr_g3", glog[3], 1);
    end

    // credit exhaustion on VC0
    refill();
    start(0, 10, 0); drive(); glog.delete();
    run(10);
    chk("exhaust_sent", glog.size(), 8);
    chk("exhaust_ready0", req_ready[0], 1'b0);
    flow_ctrl_in = 2'b01; step();
    glog.delete(); step();
    chk("credit_resume", glog.size(), 1);
    flow_ctrl_in = 2'b01; step();
    step();
    refill();

    // same-cycle send and return on VC1 at credit 3
    start(3, 5, 1); drive(); run(5);
    chk("vc1_at3", dut.credit_q[1], 4'd3);
    start(3, 1, 1); drive(); flow_ctrl_in = 2'b11; step();
    step();
    chk("same_cycle_credit1", dut.credit_q[1], 4'd3);

    // over-return on a full VC0
    chk("err_before_sat", error, 1'b0);
    flow_ctrl_in = 2'b01; step(); step();
    chk("sat_error", error, 1'b1);
    chk("sat_credit0", dut.credit_q[0], 4'd8);

    // head presented while locked
    reset = 1; step(); reset = 0; refill();
    start(0, 3, 1); drive(); step();
    req_head[0] = 1'b1; step();
    run(2);
    chk("head_in_lock_err", error, 1'b1);

    // reset mid-packet
    reset = 1; step(); reset = 0; step();
    start(2, 3, 0); drive(); run(2);
    reset = 1; req_valid = '0; step(); reset = 0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_credit0", dut.credit_q[0], 4'd8);
    step();
    chk("mid_rst_ready2", req_ready[2], 1'b0);
    step();
    chk("mid_rst_error", error, 1'b1);
    g_active[2] = 0; drive();

    // random traffic
    gaps = 1;
    for (int c = 0; c < 400; c++) begin
      int v;
      for (int i = 0; i < NR; i++)
        if (!g_active[i] && $urandom_range(0, 3) == 0)
          start(i, $urandom_range(1, 5), $urandom_range(0, 1));
      drive();
      v = $urandom_range(0, 1);
      if (m_credit[v] < BUF && $urandom_range(0, 1) == 1) flow_ctrl_in = {1'(v), 1'b1};
      step();
    end
    gaps = 0;
    begin
      int budget = 300;
      drive();
      while (any_active() && budget > 0) begin
        if (m_credit[0] < BUF) flow_ctrl_in = 2'b01;
        else if (m_credit[1] < BUF) flow_ctrl_in = 2'b11;
        step();
        budget--;
      end
      chk("drain_done", any_active(), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
